// File: rtl/dot_led_vdma_pkg.sv
// Shared register map, bit positions and response codes for the dot-LED VDMA control slave.
package dot_led_vdma_pkg;

  typedef enum logic [2:0] {
    SlotCtrl     = 3'd0,
    SlotFbBase   = 3'd1,
    SlotScratch  = 3'd2,
    SlotStatus   = 3'd3,
    SlotFrameCnt = 3'd4
  } reg_slot_e;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlStart  = 1;
  localparam int unsigned CtrlIeDone = 2;
  localparam int unsigned CtrlIeErr  = 3;

  localparam int unsigned StatBusy = 0;
  localparam int unsigned StatDone = 1;
  localparam int unsigned StatErr  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dot_led_vdma_ctrl_regs.sv
// AXI4-Lite register file controlling the dot-LED VDMA read engine: CTRL, FB_BASE, SCRATCH,
// sticky STATUS with level interrupt, and a free-running completed-frame counter.
module dot_led_vdma_ctrl_regs
  import dot_led_vdma_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_FRAME_CNT_WIDTH  = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            enable_o,
  output logic                            start_o,
  output logic [31:0]                     fb_base_o,
  input  logic                            busy_i,
  input  logic                            frame_done_i,
  input  logic                            dma_error_i,
  output logic                            irq_o
);

  // Keeps all READYs low while reset is asserted and for the first edge after release.
  logic        rst_done_q;

  logic        aw_held_q, w_held_q;
  logic [2:0]  wslot_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic        en_q, ie_done_q, ie_err_q, start_q;
  logic [31:0] fb_base_q, scratch_q;
  logic        done_q, err_q, irq_q;
  logic [C_FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  logic        aw_hs, w_hs, ar_hs, wr_commit, wr_ok;
  logic        wr_ctrl, wr_fb, wr_scratch, wr_status;
  logic        clr_done, clr_err;
  logic [31:0] ctrl_rd, status_rd, rd_val;
  logic [1:0]  rd_resp;

  assign S_AXI_AWREADY = rst_done_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = rst_done_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_commit = aw_held_q & w_held_q;

  assign wr_ctrl    = wr_commit && (wslot_q == SlotCtrl);
  assign wr_fb      = wr_commit && (wslot_q == SlotFbBase);
  assign wr_scratch = wr_commit && (wslot_q == SlotScratch);
  assign wr_status  = wr_commit && (wslot_q == SlotStatus);
  assign wr_ok      = wr_ctrl | wr_fb | wr_scratch | wr_status;

  assign clr_done = wr_status & wstrb_q[0] & wdata_q[StatDone];
  assign clr_err  = wr_status & wstrb_q[0] & wdata_q[StatErr];

  assign ctrl_rd   = {28'd0, ie_err_q, ie_done_q, 1'b0, en_q};
  assign status_rd = {29'd0, err_q, done_q, busy_i};

  assign enable_o  = en_q;
  assign start_o   = start_q;
  assign fb_base_o = {fb_base_q[31:2], 2'b00};
  assign irq_o     = irq_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_done_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wslot_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      rst_done_q <= 1'b1;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        wslot_q   <= S_AXI_AWADDR[4:2];
      end else if (wr_commit) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end else if (wr_commit) begin
        w_held_q <= 1'b0;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (S_AXI_ARADDR[4:2])
      SlotCtrl:     rd_val = ctrl_rd;
      SlotFbBase:   rd_val = fb_base_q;
      SlotScratch:  rd_val = scratch_q;
      SlotStatus:   rd_val = status_rd;
      SlotFrameCnt: rd_val = 32'(frame_cnt_q);
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_val;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_q        <= 1'b0;
      ie_done_q   <= 1'b0;
      ie_err_q    <= 1'b0;
      start_q     <= 1'b0;
      fb_base_q   <= '0;
      scratch_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ctrl && wstrb_q[0]) begin
        en_q      <= wdata_q[CtrlEn];
        ie_done_q <= wdata_q[CtrlIeDone];
        ie_err_q  <= wdata_q[CtrlIeErr];
      end
      start_q <= wr_ctrl & wstrb_q[0] & wdata_q[CtrlStart];
      if (wr_fb)      fb_base_q <= apply_wstrb(fb_base_q, wdata_q, wstrb_q);
      if (wr_scratch) scratch_q <= apply_wstrb(scratch_q, wdata_q, wstrb_q);
      // A same-edge event pulse beats the W1C clear so no event is lost.
      done_q <= frame_done_i | (done_q & ~clr_done);
      err_q  <= dma_error_i | (err_q & ~clr_err);
      if (frame_done_i) frame_cnt_q <= frame_cnt_q + 1'b1;
      irq_q <= (done_q & ie_done_q) | (err_q & ie_err_q);
    end
  end

endmodule
